// File: rtl/edit_controller.sv
// Edit controller for a clock/time display. It debounces the four push buttons,
// switches between display views, and edits a shadow copy of the time. On commit
// it strobes load so the timekeeper takes the edited value.
module edit_controller #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] KEY,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic       edit_mode,
    output logic [1:0] dis_mode,
    output logic [1:0] field_sel,
    output logic [4:0] new_hour,
    output logic [5:0] new_min,
    output logic [5:0] new_sec,
    output logic       load
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {VIEW, EDIT, COMMIT} state_t;

    logic [3:0]         sync1, sync2;
    logic [3:0]         db, armed, ev;
    logic [3:0][CW-1:0] cnt;
    logic               act0, act1, act2, act3;

    state_t        state, state_n;
    logic [1:0]    dis_n, fs_n;
    logic [4:0]    sh_hour, hour_n;
    logic [5:0]    sh_min, min_n, sh_sec, sec_n;
    logic [IW-1:0] idle, idle_n;

    // Two-flop synchronizer; the reset value is "released" because the keys are active-low
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    // Per-key debounce. A key stays unarmed after reset until it has been seen
    // stably released, so a key held through reset cannot fire an event.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            db    <= '1;
            armed <= '0;
            ev    <= '0;
            cnt   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                ev[i] <= 1'b0;
                if (!armed[i]) begin
                    if (!sync2[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                        armed[i] <= 1'b1;
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                    ev[i]  <= ~sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Only the highest-priority event of a clock is acted on: KEY0 > KEY3 > KEY1 > KEY2
    always_comb begin
        act0 = ev[0];
        act3 = ev[3] & ~ev[0];
        act1 = ev[1] & ~ev[0] & ~ev[3];
        act2 = ev[2] & ~ev[0] & ~ev[3] & ~ev[1];
    end

    // FSM state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= VIEW;
        else     state <= state_n;
    end

    // Next-state and next-value logic for the view, field, shadow and idle registers
    always_comb begin
        state_n = state;
        dis_n   = dis_mode;
        fs_n    = field_sel;
        hour_n  = sh_hour;
        min_n   = sh_min;
        sec_n   = sh_sec;
        idle_n  = idle;
        case (state)
            VIEW: begin
                idle_n = '0;
                if (act0) begin
                    hour_n  = (cur_hour > 5'd23) ? 5'd0 : cur_hour;
                    min_n   = (cur_min > 6'd59) ? 6'd0 : cur_min;
                    sec_n   = (cur_sec > 6'd59) ? 6'd0 : cur_sec;
                    fs_n    = 2'd0;
                    state_n = EDIT;
                end else if (act1) begin
                    dis_n = (dis_mode >= 2'd2) ? 2'd0 : dis_mode + 2'd1;
                end else if (act2) begin
                    dis_n = (dis_mode == 2'd0) ? 2'd2 : dis_mode - 2'd1;
                end
            end
            EDIT: begin
                if (act0 | act1 | act2 | act3) idle_n = '0;
                if (act0) begin
                    state_n = COMMIT;
                end else if (act3) begin
                    fs_n = (field_sel >= 2'd2) ? 2'd0 : field_sel + 2'd1;
                end else if (act1) begin
                    case (field_sel)
                        2'd0:    hour_n = (sh_hour >= 5'd23) ? 5'd0 : sh_hour + 5'd1;
                        2'd1:    min_n  = (sh_min >= 6'd59) ? 6'd0 : sh_min + 6'd1;
                        default: sec_n  = (sh_sec >= 6'd59) ? 6'd0 : sh_sec + 6'd1;
                    endcase
                end else if (act2) begin
                    case (field_sel)
                        2'd0:    hour_n = (sh_hour == 5'd0) ? 5'd23 : sh_hour - 5'd1;
                        2'd1:    min_n  = (sh_min == 6'd0) ? 6'd59 : sh_min - 6'd1;
                        default: sec_n  = (sh_sec == 6'd0) ? 6'd59 : sh_sec - 6'd1;
                    endcase
                end else if (idle == IW'(TIMEOUT - 1)) begin
                    idle_n  = '0;
                    state_n = VIEW;
                end else begin
                    idle_n = idle + IW'(1);
                end
            end
            COMMIT: begin
                state_n = VIEW;
            end
            default: begin
                state_n = VIEW;
            end
        endcase
    end

    // Registered outputs and shadow registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            edit_mode <= 1'b0;
            load      <= 1'b0;
            dis_mode  <= 2'd0;
            field_sel <= 2'd0;
            sh_hour   <= 5'd0;
            sh_min    <= 6'd0;
            sh_sec    <= 6'd0;
            idle      <= '0;
        end else begin
            edit_mode <= (state_n == EDIT);
            load      <= (state_n == COMMIT);
            dis_mode  <= dis_n;
            field_sel <= fs_n;
            sh_hour   <= hour_n;
            sh_min    <= min_n;
            sh_sec    <= sec_n;
            idle      <= idle_n;
        end
    end

    assign new_hour = sh_hour;
    assign new_min  = sh_min;
    assign new_sec  = sh_sec;

endmodule

// File: tb/tb_edit_controller.sv
// Directed testbench for edit_controller, with hand-computed expected values.
module tb_edit_controller;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] KEY;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic       edit_mode, load;
    logic [1:0] dis_mode, field_sel;
    logic [4:0] new_hour;
    logic [5:0] new_min, new_sec;

    int n_cmp = 0;
    int n_err = 0;
    int load_total = 0;
    int load_base;
    logic [4:0] cap_hour = '0;
    logic [5:0] cap_min = '0, cap_sec = '0;

    edit_controller dut (
        .Clk(Clk), .Rst(Rst), .KEY(KEY),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .edit_mode(edit_mode), .dis_mode(dis_mode), .field_sel(field_sel),
        .new_hour(new_hour), .new_min(new_min), .new_sec(new_sec),
        .load(load)
    );

    always #5 Clk = ~Clk;

    // Count load strobes and capture the values presented with them
    always @(negedge Clk) begin
        if (load) begin
            load_total = load_total + 1;
            cap_hour   = new_hour;
            cap_min    = new_min;
            cap_sec    = new_sec;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic press(input int k);
        KEY[k] = 1'b0;
        cycles(10);
        KEY[k] = 1'b1;
        cycles(10);
    endtask

    initial begin
        Rst = 1'b1;
        KEY = 4'hF;
        cur_hour = 5'd0; cur_min = 6'd0; cur_sec = 6'd0;
        cycles(3);
        check("rst_edit_mode", 32'(edit_mode), 32'd0);
        check("rst_dis_mode", 32'(dis_mode), 32'd0);
        check("rst_field_sel", 32'(field_sel), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_new_hour", 32'(new_hour), 32'd0);
        check("rst_new_sec", 32'(new_sec), 32'd0);
        Rst = 1'b0;
        cycles(10);

        // View cycling with KEY1
        press(1);
        check("view_1", 32'(dis_mode), 32'd1);
        press(1);
        check("view_2", 32'(dis_mode), 32'd2);
        press(1);
        check("view_0", 32'(dis_mode), 32'd0);
        check("view_edit_mode", 32'(edit_mode), 32'd0);
        check("view_no_load", 32'(load_total), 32'd0);
        press(2);
        check("view_down_2", 32'(dis_mode), 32'd2);
        press(2);
        check("view_down_1", 32'(dis_mode), 32'd1);
        press(2);
        check("view_down_0", 32'(dis_mode), 32'd0);

        // Hour wrap 23 -> 0 and commit
        cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd58;
        press(0);
        check("enter_edit", 32'(edit_mode), 32'd1);
        check("enter_field", 32'(field_sel), 32'd0);
        check("enter_hour", 32'(new_hour), 32'd23);
        press(1);
        check("hour_wrap", 32'(new_hour), 32'd0);
        load_base = load_total;
        press(0);
        check("commit1_loads", 32'(load_total - load_base), 32'd1);
        check("commit1_hour", 32'(cap_hour), 32'd0);
        check("commit1_min", 32'(cap_min), 32'd59);
        check("commit1_sec", 32'(cap_sec), 32'd58);
        check("commit1_exit", 32'(edit_mode), 32'd0);

        // Field select and second wrap 0 -> 59
        cur_hour = 5'd10; cur_min = 6'd20; cur_sec = 6'd0;
        press(0);
        cur_hour = 5'd3; cur_min = 6'd4; cur_sec = 6'd5;
        press(3);
        check("field_1", 32'(field_sel), 32'd1);
        press(3);
        check("field_2", 32'(field_sel), 32'd2);
        press(2);
        check("sec_wrap", 32'(new_sec), 32'd59);
        press(3);
        check("field_0", 32'(field_sel), 32'd0);
        load_base = load_total;
        press(0);
        check("commit2_loads", 32'(load_total - load_base), 32'd1);
        check("commit2_hour", 32'(cap_hour), 32'd10);
        check("commit2_min", 32'(cap_min), 32'd20);
        check("commit2_sec", 32'(cap_sec), 32'd59);

        // Bouncing KEY1 then a long hold gives one increment
        cur_hour = 5'd5; cur_min = 6'd6; cur_sec = 6'd7;
        press(0);
        for (int i = 0; i < 5; i++) begin
            KEY[1] = 1'b0;
            cycles(2);
            KEY[1] = 1'b1;
            cycles(2);
        end
        KEY[1] = 1'b0;
        cycles(50);
        KEY[1] = 1'b1;
        cycles(10);
        check("bounce_hour", 32'(new_hour), 32'd6);
        check("bounce_still_edit", 32'(edit_mode), 32'd1);

        // Idle timeout returns to view without a load
        load_base = load_total;
        cycles(1020);
        check("timeout_exit", 32'(edit_mode), 32'd0);
        check("timeout_no_load", 32'(load_total - load_base), 32'd0);

        // KEY0 and KEY1 in the same clock: edit wins, view untouched
        press(1);
        check("pre_same_view", 32'(dis_mode), 32'd1);
        KEY = 4'b1100;
        cycles(10);
        KEY = 4'hF;
        cycles(10);
        check("same_clk_edit", 32'(edit_mode), 32'd1);
        check("same_clk_view", 32'(dis_mode), 32'd1);

        // Reset mid-edit clears everything at once; held key stays ignored
        press(1);
        check("pre_rst_hour", 32'(new_hour), 32'd6);
        load_base = load_total;
        #2 Rst = 1'b1;
        #1;
        check("arst_edit_mode", 32'(edit_mode), 32'd0);
        check("arst_dis_mode", 32'(dis_mode), 32'd0);
        check("arst_new_hour", 32'(new_hour), 32'd0);
        check("arst_new_min", 32'(new_min), 32'd0);
        KEY[0] = 1'b0;
        cycles(3);
        Rst = 1'b0;
        cycles(20);
        check("held_no_event", 32'(edit_mode), 32'd0);
        check("arst_no_load", 32'(load_total - load_base), 32'd0);
        KEY[0] = 1'b1;
        cycles(10);
        press(0);
        check("repress_edit", 32'(edit_mode), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
